// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk cycles.
// Define PERIOD_METER_AVG4_EN to average the period over four consecutive cycles.
module period_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2   // must be >= 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             ack,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             overflow
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOW,
    WAIT_RISE,
    MEASURE,
    DONE
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sig_dly_q, sig_dly_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic [CNT_W-1:0]       high_q, high_d;
  logic                   ovf_q, ovf_d;
  logic                   fall_seen_q, fall_seen_d;
`ifdef PERIOD_METER_AVG4_EN
  logic [CNT_W+1:0]       sum_q, sum_d;
  logic [CNT_W+1:0]       sum_next;
  logic [1:0]             idx_q, idx_d;
`endif

  logic             sig_s;
  logic             rise;
  logic             fall;
  logic             cnt_sat;
  logic [CNT_W-1:0] cnt_inc;

  assign sig_s   = sync_q[SYNC_STAGES-1];
  assign rise    = sig_s & ~sig_dly_q;
  assign fall    = ~sig_s & sig_dly_q;
  assign cnt_sat = (cnt_q == CNT_MAX);
  assign cnt_inc = cnt_sat ? cnt_q : cnt_q + CNT_ONE;

  assign busy      = (state_q != IDLE);
  assign valid     = (state_q == DONE);
  assign period    = period_q;
  assign high_time = high_q;
  assign overflow  = ovf_q;

  always_comb begin
    // NOTE: every combinational output gets its hold value first, so no path can infer a latch.
    state_d     = state_q;
    sync_d      = {sync_q[SYNC_STAGES-2:0], sig_in};
    sig_dly_d   = sig_s;
    cnt_d       = cnt_q;
    period_d    = period_q;
    high_d      = high_q;
    ovf_d       = ovf_q;
    fall_seen_d = fall_seen_q;
`ifdef PERIOD_METER_AVG4_EN
    sum_d       = sum_q;
    idx_d       = idx_q;
    sum_next    = sum_q + (CNT_W+2)'(cnt_q);
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = WAIT_LOW;
          cnt_d       = '0;
          period_d    = '0;
          high_d      = '0;
          ovf_d       = 1'b0;
          fall_seen_d = 1'b0;
`ifdef PERIOD_METER_AVG4_EN
          sum_d       = '0;
          idx_d       = '0;
`endif
        end
      end

      // A level already high at start must not be taken for a rising edge.
      WAIT_LOW, WAIT_RISE: begin
        if ((state_q == WAIT_LOW) && !sig_s) begin
          state_d = WAIT_RISE;
          cnt_d   = CNT_ONE;
        end else if ((state_q == WAIT_RISE) && rise) begin
          state_d = MEASURE;
          cnt_d   = CNT_ONE;
        end else if (cnt_sat) begin
          state_d  = DONE;
          ovf_d    = 1'b1;
          period_d = CNT_MAX;
          high_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      MEASURE: begin
        if (rise) begin
          cnt_d = CNT_ONE;
`ifdef PERIOD_METER_AVG4_EN
          if (idx_q == 2'd3) begin
            state_d  = DONE;
            period_d = sum_next[CNT_W+1:2];
          end else begin
            // Only the fourth period's high time is reported.
            idx_d       = idx_q + 2'd1;
            sum_d       = sum_next;
            high_d      = '0;
            fall_seen_d = 1'b0;
          end
`else
          state_d  = DONE;
          period_d = cnt_q;
`endif
        end else begin
          if (fall) begin
            high_d      = cnt_q;
            fall_seen_d = 1'b1;
          end
          if (cnt_sat) begin
            state_d  = DONE;
            ovf_d    = 1'b1;
            period_d = CNT_MAX;
            if (!fall && !fall_seen_q) high_d = CNT_MAX;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      DONE: begin
        if (ack) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      sig_dly_q   <= 1'b0;
      cnt_q       <= '0;
      period_q    <= '0;
      high_q      <= '0;
      ovf_q       <= 1'b0;
      fall_seen_q <= 1'b0;
`ifdef PERIOD_METER_AVG4_EN
      sum_q       <= '0;
      idx_q       <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      sync_q      <= sync_d;
      sig_dly_q   <= sig_dly_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      high_q      <= high_d;
      ovf_q       <= ovf_d;
      fall_seen_q <= fall_seen_d;
`ifdef PERIOD_METER_AVG4_EN
      sum_q       <= sum_d;
      idx_q       <= idx_d;
`endif
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter (CNT_W = 8): directed waveforms, a
// period/high-time model of the expected result and a per-cycle compare process.
module tb_period_meter;

  localparam int CNT_W = 8;
  localparam int MAXV  = (1 << CNT_W) - 1;
`ifdef PERIOD_METER_AVG4_EN
  localparam int N_AVG = 4;
`else
  localparam int N_AVG = 1;
`endif

  typedef enum int { M_WAVE, M_STUCK_LOW, M_STUCK_HIGH } mode_e;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             sig_in;
  logic             start;
  logic             ack;
  logic             busy;
  logic             valid;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             overflow;

  int total = 0;
  int bad   = 0;

  int seg_p[$];
  int seg_h[$];
  bit exp_armed = 1'b0;
  int exp_period;
  int exp_high;
  int exp_ovf;

  period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .start     (start),
    .ack       (ack),
    .busy      (busy),
    .valid     (valid),
    .period    (period),
    .high_time (high_time),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Expected result from the measurement rules: periods are segment lengths
  // between consecutive rises, averaged over N_AVG of them.
  function automatic void model_set(input mode_e m);
    int sum;
    case (m)
      M_STUCK_LOW: begin
        exp_period = MAXV; exp_high = 0; exp_ovf = 1;
      end
      M_STUCK_HIGH: begin
        exp_period = MAXV; exp_high = MAXV; exp_ovf = 1;
      end
      default: begin
        sum = 0;
        for (int i = 0; i < N_AVG; i++) sum += seg_p[i % seg_p.size()];
        exp_period = sum / N_AVG;
        exp_high   = seg_h[(N_AVG - 1) % seg_h.size()];
        exp_ovf    = 0;
      end
    endcase
  endfunction

  // Sampled 2 time units after each rising edge, away from the negedge drive.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rst_n === 1'b1) begin
        if (!exp_armed) begin
          check("valid_unexpected", valid, 1'b0);
        end else if (valid) begin
          check("cmp_period", period, exp_period);
          check("cmp_high_time", high_time, exp_high);
          check("cmp_overflow", overflow, exp_ovf);
          check("cmp_busy_in_done", busy, 1'b1);
        end
      end
    end
  end

  task automatic begin_meas(input logic lvl);
    sig_in = lvl;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Plays the segment list cyclically (high first) until valid or a bound is hit.
  task automatic drive(input int budget, input int start_at, input int rst_at, output bit got);
    int idx = 0;
    int off = 0;
    got = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      if (valid) begin
        got = 1'b1;
        start = 1'b0;
        return;
      end
      if (cyc == rst_at) begin
        rst_n = 1'b0;
        exp_armed = 1'b0;
        return;
      end
      start  = (cyc == start_at);
      sig_in = (off < seg_h[idx]);
      off++;
      if (off >= seg_p[idx]) begin
        off = 0;
        idx = (idx + 1) % seg_p.size();
      end
    end
    start = 1'b0;
  endtask

  task automatic measure(input string name, input mode_e m, input int budget, input int start_at);
    bit got;
    model_set(m);
    exp_armed = 1'b1;
    begin_meas(1'b0);
    drive(budget, start_at, -1, got);
    check(name, got, 1'b1);
  endtask

  task automatic do_ack(input logic with_start);
    ack   = 1'b1;
    start = with_start;
    exp_armed = 1'b0;
    @(negedge clk);
    ack   = 1'b0;
    start = 1'b0;
    check("ack_valid_fall", valid, 1'b0);
    check("ack_busy_fall", busy, 1'b0);
    repeat (4) @(negedge clk);
    check("ack_stays_idle", busy, 1'b0);
  endtask

  initial begin
    bit got;
    rst_n  = 1'b0;
    sig_in = 1'b1;
    start  = 1'b0;
    ack    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_valid", valid, 1'b0);
    check("rst_period", period, 0);
    check("rst_high_time", high_time, 0);
    check("rst_overflow", overflow, 1'b0);
    rst_n = 1'b1;

    // Level high through reset and start: no edge until a real low->high.
    seg_p = '{7}; seg_h = '{4};
    model_set(M_WAVE);
    exp_armed = 1'b1;
    begin_meas(1'b1);
    repeat (16) @(negedge clk);
    check("high_hold_busy", busy, 1'b1);
    check("high_hold_no_valid", valid, 1'b0);
    drive(400, -1, -1, got);
    check("high_hold_done", got, 1'b1);
    check("high_hold_period", period, 7);
    check("high_hold_high", high_time, 4);
    do_ack(1'b0);

    // Clean 10/3 wave, result held without ack.
    seg_p = '{10}; seg_h = '{3};
    measure("clean_done", M_WAVE, 400, -1);
    check("clean_period", period, 10);
    check("clean_high", high_time, 3);
    check("clean_ovf", overflow, 1'b0);
    sig_in = 1'b0;
    repeat (20) @(negedge clk);
    check("clean_hold_valid", valid, 1'b1);
    check("clean_hold_period", period, 10);
    do_ack(1'b0);

    // clk/2 toggle.
    seg_p = '{2}; seg_h = '{1};
    measure("fast_done", M_WAVE, 200, -1);
    check("fast_period", period, 2);
    check("fast_high", high_time, 1);
    do_ack(1'b0);

    // Stuck low after start.
    seg_p = '{1}; seg_h = '{0};
    measure("stuck_low_done", M_STUCK_LOW, 1500, -1);
    check("stuck_low_period", period, MAXV);
    check("stuck_low_high", high_time, 0);
    check("stuck_low_ovf", overflow, 1'b1);
    do_ack(1'b0);

    // Stuck high after one rise.
    seg_p = '{3000}; seg_h = '{3000};
    measure("stuck_high_done", M_STUCK_HIGH, 1500, -1);
    check("stuck_high_period", period, MAXV);
    check("stuck_high_high", high_time, MAXV);
    check("stuck_high_ovf", overflow, 1'b1);
    do_ack(1'b0);

    // start pulsed mid-measurement, then ack+start together in DONE.
    seg_p = '{12}; seg_h = '{6};
    measure("mid_start_done", M_WAVE, 400, 8);
    check("mid_start_period", period, 12);
    check("mid_start_high", high_time, 6);
    do_ack(1'b1);

    // Reset mid-measurement, after a fall has already been captured.
    seg_p = '{20}; seg_h = '{10};
    model_set(M_WAVE);
    exp_armed = 1'b1;
    begin_meas(1'b0);
    drive(100, -1, 15, got);
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_valid", valid, 1'b0);
    check("mid_rst_period", period, 0);
    check("mid_rst_high", high_time, 0);
    check("mid_rst_ovf", overflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    seg_p = '{5}; seg_h = '{2};
    measure("post_rst_done", M_WAVE, 200, -1);
    check("post_rst_period", period, 5);
    check("post_rst_high", high_time, 2);
    do_ack(1'b0);

`ifdef PERIOD_METER_AVG4_EN
    seg_p = '{8, 9, 10, 12}; seg_h = '{3, 4, 5, 7};
    measure("avg_done", M_WAVE, 400, -1);
    check("avg_period", period, 9);
    check("avg_high", high_time, 7);
    check("avg_ovf", overflow, 1'b0);
    do_ack(1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
